// File: rtl/l2_victim_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : l2_victim_buffer
//  Purpose  : Single-entry write-back victim buffer between the L2 cache and
//             physical memory. A dirty eviction is absorbed in one cycle so the
//             following line fill reaches memory first. The buffered victim is
//             drained whenever the memory port is otherwise idle. Reads that
//             hit the buffered line are answered locally.
//  Ports    : clk, reset (async, active-high)
//             l2_read/l2_write/l2_address/l2_wdata  -> L2 request side
//             l2_rdata/l2_resp                      <- L2 response side
//             pmem_read/pmem_write/pmem_address/pmem_wdata -> memory request
//             pmem_rdata/pmem_resp                  <- memory response
//  Revision : 1.0  initial release
// ============================================================================
module l2_victim_buffer (
   input  logic         clk,
   input  logic         reset,
   input  logic         l2_read,
   input  logic         l2_write,
   input  logic [15:0]  l2_address,
   input  logic [127:0] l2_wdata,
   output logic [127:0] l2_rdata,
   output logic         l2_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [2:0] {
      ST_EMPTY     = 3'd0,
      ST_FULL      = 3'd1,
      ST_ACK       = 3'd2,
      ST_MEM_READ  = 3'd3,
      ST_MEM_WRITE = 3'd4
   } state_t;

   state_t         state_q,    state_d;
   logic           vb_valid_q, vb_valid_d;
   logic [11:0]    vb_tag_q,   vb_tag_d;
   logic [127:0]   vb_data_q,  vb_data_d;
   logic [127:0]   rdata_q,    rdata_d;

   logic [11:0]    req_tag;
   logic           hit;
   logic           unused_addr_bits;

   assign req_tag          = l2_address[15:4];
   assign hit              = vb_valid_q && (req_tag == vb_tag_q);
   // Offset bits inside the line carry no meaning for line-granular traffic.
   assign unused_addr_bits = ^l2_address[3:0];

   // ------------------------------------------------------------------
   // State and storage registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         vb_valid_q <= 1'b0;
         vb_tag_q   <= 12'h000;
         vb_data_q  <= 128'h0;
         rdata_q    <= 128'h0;
      end else begin
         state_q    <= state_d;
         vb_valid_q <= vb_valid_d;
         vb_tag_q   <= vb_tag_d;
         vb_data_q  <= vb_data_d;
         rdata_q    <= rdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and storage update
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      vb_valid_d = vb_valid_q;
      vb_tag_d   = vb_tag_q;
      vb_data_d  = vb_data_q;
      rdata_d    = rdata_q;

      case (state_q)
         ST_EMPTY: begin
            if (l2_read) begin
               state_d = ST_MEM_READ;
            end else if (l2_write) begin
               vb_valid_d = 1'b1;
               vb_tag_d   = req_tag;
               vb_data_d  = l2_wdata;
               state_d    = ST_ACK;
            end
         end

         ST_FULL: begin
            if (l2_read) begin
               if (hit) begin
                  rdata_d = vb_data_q;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_MEM_READ;
               end
            end else if (l2_write) begin
               if (hit) begin
                  // Newer copy of the same line simply replaces the victim.
                  vb_data_d = l2_wdata;
                  state_d   = ST_ACK;
               end else begin
                  // Drain the old victim; the held write is captured from EMPTY.
                  state_d = ST_MEM_WRITE;
               end
            end else begin
               state_d = ST_MEM_WRITE;
            end
         end

         ST_MEM_READ: begin
            if (pmem_resp) begin
               rdata_d = pmem_rdata;
               state_d = ST_ACK;
            end
         end

         ST_MEM_WRITE: begin
            if (pmem_resp) begin
               vb_valid_d = 1'b0;
               state_d    = ST_EMPTY;
            end
         end

         ST_ACK: begin
            state_d = vb_valid_q ? ST_FULL : ST_EMPTY;
         end

         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Moore outputs: decoded from the state register only. The read address
   // tracks l2_address, which the L2 holds steady until l2_resp.
   // ------------------------------------------------------------------
   always_comb begin
      l2_resp      = 1'b0;
      l2_rdata     = 128'h0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0000;
      pmem_wdata   = 128'h0;

      case (state_q)
         ST_ACK: begin
            l2_resp  = 1'b1;
            l2_rdata = rdata_q;
         end
         ST_MEM_READ: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, 4'h0};
         end
         ST_MEM_WRITE: begin
            pmem_write   = 1'b1;
            pmem_address = {vb_tag_q, 4'h0};
            pmem_wdata   = vb_data_q;
         end
         default: begin
            l2_resp = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_victim_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_victim_buffer
//  Purpose  : Self-checking bench for l2_victim_buffer. A behavioural memory
//             with adjustable latency answers the pmem port and logs every
//             completed transaction; a line-level golden image of memory
//             holds the value the L2 should always observe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_victim_buffer;

   logic         clk;
   logic         reset;
   logic         l2_read;
   logic         l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic [127:0] l2_rdata;
   logic         l2_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   typedef struct {
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } pmem_txn_t;

   pmem_txn_t    log_q[$];
   logic [127:0] mem    [0:4095];
   logic [127:0] golden [0:4095];

   int n_checks = 0;
   int n_pass   = 0;
   int mem_lat  = 1;

   l2_victim_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .l2_read      (l2_read),
      .l2_write     (l2_write),
      .l2_address   (l2_address),
      .l2_wdata     (l2_wdata),
      .l2_rdata     (l2_rdata),
      .l2_resp      (l2_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ------------------------------------------------------------------
   // Behavioural memory: responds after mem_lat cycles of a held request,
   // checks the request stays stable, and logs each completed transaction.
   // ------------------------------------------------------------------
   initial begin : memory_model
      int           cnt;
      logic [15:0]  st_addr;
      logic [127:0] st_wdata;
      bit           st_wr;
      cnt        = 0;
      st_addr    = '0;
      st_wdata   = '0;
      st_wr      = 1'b0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            pmem_resp = 1'b0;
            cnt       = 0;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt       = 0;
         end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == 1) begin
               st_addr  = pmem_address;
               st_wdata = pmem_wdata;
               st_wr    = pmem_write;
               n_checks++;
               if (pmem_address[3:0] !== 4'h0 || (pmem_read && pmem_write))
                  $display("FAIL pmem_request_shape: addr=%h rd=%b wr=%b, required addr[3:0]=0 and one command", pmem_address, pmem_read, pmem_write);
               else
                  n_pass++;
            end else begin
               n_checks++;
               if (pmem_address !== st_addr || pmem_write !== st_wr || (st_wr && pmem_wdata !== st_wdata))
                  $display("FAIL pmem_stable: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h", pmem_address, pmem_write, pmem_wdata, st_addr, st_wr, st_wdata);
               else
                  n_pass++;
            end
            if (cnt >= mem_lat) begin
               pmem_resp = 1'b1;
               if (pmem_write) begin
                  mem[pmem_address[15:4]] = pmem_wdata;
                  log_q.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
               end else begin
                  pmem_rdata = mem[pmem_address[15:4]];
                  log_q.push_back('{wr: 1'b0, addr: pmem_address, data: pmem_rdata});
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers. All driving happens 1 time unit after a rising edge.
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      l2_read  = 1'b0;
      l2_write = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issues one L2 request, holds it until l2_resp, then drops it. lat is the
   // number of rising edges from assertion until l2_resp is visible.
   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                         output logic [127:0] rd, output int lat);
      l2_read    = !wr;
      l2_write   = wr;
      l2_address = addr;
      l2_wdata   = data;
      lat        = 0;
      rd         = '0;
      while (1) begin
         @(posedge clk);
         #1;
         lat++;
         if (l2_resp === 1'b1 || lat >= 200) break;
      end
      rd       = l2_rdata;
      l2_read  = 1'b0;
      l2_write = 1'b0;
      n_checks++;
      if (l2_resp !== 1'b1)
         $display("FAIL req_timeout: no l2_resp after %0d cycles for addr %h, required a response", lat, addr);
      else
         n_pass++;
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset      = 1'b1;
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_address = '0;
      l2_wdata   = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({l2_resp, pmem_read, pmem_write} !== 3'b000 || l2_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0)
            $display("FAIL reset_outputs: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, required all 0", l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, l2_rdata);
         else
            n_pass++;
      end
      reset = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({l2_resp, pmem_read, pmem_write} !== 3'b000 || l2_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0)
            $display("FAIL idle_outputs: resp=%b rd=%b wr=%b addr=%h wdata=%h, required all 0", l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata);
         else
            n_pass++;
      end
   endtask

   // Eviction then a back-to-back miss read: the fill must precede the drain.
   task automatic test_write_then_miss();
      logic [127:0] a, rd;
      int lat;
      a = rand128();
      log_q.delete();
      mem_lat = 5;
      do_req(1'b1, 16'h1230, a, rd, lat);
      golden[12'h123] = a;
      n_checks++;
      if (lat != 1) $display("FAIL write_empty_latency: got %0d, required 1", lat);
      else n_pass++;
      // request issued during ACK: one edge ACK->FULL, one FULL->MEM_READ, then memory latency
      do_req(1'b0, 16'h4560, '0, rd, lat);
      n_checks++;
      if (lat != 7) $display("FAIL miss_read_latency: got %0d, required 7", lat);
      else n_pass++;
      n_checks++;
      if (rd !== golden[12'h456]) $display("FAIL miss_read_data: got %h, required %h", rd, golden[12'h456]);
      else n_pass++;
      n_checks++;
      if (log_q.size() != 1) $display("FAIL read_before_flush: %0d pmem transactions, required 1", log_q.size());
      else if (log_q[0].wr || log_q[0].addr !== 16'h4560) $display("FAIL read_before_flush: wr=%b addr=%h, required read at 4560", log_q[0].wr, log_q[0].addr);
      else n_pass++;
      idle(20);
      n_checks++;
      if (log_q.size() != 2) $display("FAIL flush_after_read: %0d pmem transactions, required 2", log_q.size());
      else if (!log_q[1].wr || log_q[1].addr !== 16'h1230 || log_q[1].data !== a)
         $display("FAIL flush_after_read: wr=%b addr=%h data=%h, required write 1230 data %h", log_q[1].wr, log_q[1].addr, log_q[1].data, a);
      else n_pass++;
   endtask

   task automatic test_hit_read();
      logic [127:0] a, rd;
      int lat;
      a = rand128();
      log_q.delete();
      mem_lat = 2;
      do_req(1'b1, 16'h1230, a, rd, lat);
      golden[12'h123] = a;
      n_checks++;
      if (lat != 1) $display("FAIL hit_setup_latency: got %0d, required 1", lat);
      else n_pass++;
      do_req(1'b0, 16'h123E, '0, rd, lat);
      n_checks++;
      if (lat != 2) $display("FAIL hit_read_latency: got %0d, required 2", lat);
      else n_pass++;
      n_checks++;
      if (rd !== a) $display("FAIL hit_read_data: got %h, required %h", rd, a);
      else n_pass++;
      n_checks++;
      if (log_q.size() != 0) $display("FAIL hit_no_pmem: %0d pmem transactions, required 0", log_q.size());
      else n_pass++;
      idle(20);
   endtask

   task automatic test_coalesce();
      logic [127:0] a, b, rd;
      int lat;
      a = rand128();
      b = rand128();
      log_q.delete();
      mem_lat = 3;
      do_req(1'b1, 16'h1230, a, rd, lat);
      do_req(1'b1, 16'h1230, b, rd, lat);
      golden[12'h123] = b;
      n_checks++;
      if (lat != 2) $display("FAIL coalesce_latency: got %0d, required 2", lat);
      else n_pass++;
      idle(20);
      n_checks++;
      if (log_q.size() != 1) $display("FAIL coalesce_single_write: %0d pmem transactions, required 1", log_q.size());
      else if (!log_q[0].wr || log_q[0].addr !== 16'h1230 || log_q[0].data !== b)
         $display("FAIL coalesce_single_write: wr=%b addr=%h data=%h, required write 1230 data %h", log_q[0].wr, log_q[0].addr, log_q[0].data, b);
      else n_pass++;
   endtask

   task automatic test_write_miss();
      logic [127:0] a, c, rd;
      int lat;
      a = rand128();
      c = rand128();
      log_q.delete();
      mem_lat = 3;
      do_req(1'b1, 16'h1230, a, rd, lat);
      golden[12'h123] = a;
      do_req(1'b1, 16'h7770, c, rd, lat);
      golden[12'h777] = c;
      // ACK->FULL, FULL->MEM_WRITE, 3 memory cycles, ->EMPTY, capture ->ACK
      n_checks++;
      if (lat != 6) $display("FAIL write_miss_latency: got %0d, required 6", lat);
      else n_pass++;
      n_checks++;
      if (log_q.size() != 1) $display("FAIL old_victim_first: %0d pmem transactions, required 1", log_q.size());
      else if (!log_q[0].wr || log_q[0].addr !== 16'h1230 || log_q[0].data !== a)
         $display("FAIL old_victim_first: wr=%b addr=%h data=%h, required write 1230 data %h", log_q[0].wr, log_q[0].addr, log_q[0].data, a);
      else n_pass++;
      idle(20);
      n_checks++;
      if (log_q.size() != 2) $display("FAIL new_victim_flush: %0d pmem transactions, required 2", log_q.size());
      else if (!log_q[1].wr || log_q[1].addr !== 16'h7770 || log_q[1].data !== c)
         $display("FAIL new_victim_flush: wr=%b addr=%h data=%h, required write 7770 data %h", log_q[1].wr, log_q[1].addr, log_q[1].data, c);
      else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      logic [127:0] d, rd;
      int lat, w;
      d = rand128();
      mem_lat = 20;
      do_req(1'b1, 16'h1230, d, rd, lat);
      w = 0;
      while (pmem_write !== 1'b1 && w < 10) begin
         @(posedge clk);
         #1;
         w++;
      end
      n_checks++;
      if (pmem_write !== 1'b1) $display("FAIL flush_started: pmem_write=%b, required 1", pmem_write);
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== '0)
         $display("FAIL async_reset_drop: wr=%b rd=%b addr=%h, required 0 0 0000", pmem_write, pmem_read, pmem_address);
      else n_pass++;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      // the victim was discarded, so memory still holds the line's old value
      golden[12'h123] = mem[12'h123];
      mem_lat = 4;
      log_q.delete();
      do_req(1'b0, 16'h1230, '0, rd, lat);
      n_checks++;
      if (lat != 5) $display("FAIL post_reset_read_latency: got %0d, required 5", lat);
      else n_pass++;
      n_checks++;
      if (rd !== golden[12'h123]) $display("FAIL post_reset_no_stale_hit: got %h, required %h", rd, golden[12'h123]);
      else n_pass++;
      n_checks++;
      if (log_q.size() != 1 || log_q[0].wr || log_q[0].addr !== 16'h1230)
         $display("FAIL post_reset_pmem_read: %0d transactions, required one read at 1230", log_q.size());
      else n_pass++;
      idle(10);
   endtask

   // Random reads/writes over four lines with random gaps and latencies.
   // The bench tracks only which line is known to sit in the buffer, learned
   // from the drain writes the memory model sees.
   task automatic test_random();
      logic [11:0]  lines [4];
      bit           buf_valid;
      logic [11:0]  buf_line;
      logic [127:0] d, rd;
      logic [11:0]  ln;
      logic [15:0]  addr;
      int           ptr, lat, gap, nreads;
      bit           wr, sure_hit, sure_miss, bad_addr;
      lines[0] = 12'h123;
      lines[1] = 12'h456;
      lines[2] = 12'h777;
      lines[3] = 12'hABC;
      buf_valid = 1'b0;
      buf_line  = '0;
      log_q.delete();
      ptr = 0;
      for (int i = 0; i < 60; i++) begin
         gap = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
         if (gap > 0) idle(gap);
         for (int k = ptr; k < log_q.size(); k++)
            if (log_q[k].wr && buf_valid && log_q[k].addr[15:4] == buf_line) buf_valid = 1'b0;
         ptr       = log_q.size();
         wr        = 1'($urandom_range(0, 1));
         ln        = lines[$urandom_range(0, 3)];
         addr      = {ln, 4'($urandom_range(0, 15))};
         d         = rand128();
         mem_lat   = $urandom_range(1, 4);
         sure_hit  = buf_valid && buf_line == ln && gap == 0;
         sure_miss = !(buf_valid && buf_line == ln);
         do_req(wr, addr, d, rd, lat);
         nreads   = 0;
         bad_addr = 1'b0;
         for (int k = ptr; k < log_q.size(); k++) begin
            if (!log_q[k].wr) begin
               nreads++;
               if (log_q[k].addr !== {ln, 4'h0}) bad_addr = 1'b1;
            end else if (buf_valid && log_q[k].addr[15:4] == buf_line) begin
               buf_valid = 1'b0;
            end
         end
         ptr = log_q.size();
         if (wr) begin
            golden[ln] = d;
            buf_valid  = 1'b1;
            buf_line   = ln;
            n_checks++;
            if (nreads != 0) $display("FAIL rand_write_no_read: %0d pmem reads during write to %h, required 0", nreads, addr);
            else n_pass++;
         end else begin
            n_checks++;
            if (rd !== golden[ln]) $display("FAIL rand_read_data: addr %h got %h, required %h", addr, rd, golden[ln]);
            else n_pass++;
            n_checks++;
            if (sure_hit && nreads != 0)
               $display("FAIL rand_hit_local: %0d pmem reads for buffered line %h, required 0", nreads, addr);
            else if (sure_miss && (nreads != 1 || bad_addr))
               $display("FAIL rand_miss_fetch: %0d pmem reads (bad addr %b) for %h, required 1 at line", nreads, bad_addr, addr);
            else if (nreads > 1)
               $display("FAIL rand_read_count: %0d pmem reads for %h, required at most 1", nreads, addr);
            else n_pass++;
         end
         n_checks++;
         if (lat > 20) $display("FAIL rand_latency_bound: got %0d, required <= 20", lat);
         else n_pass++;
      end
      idle(40);
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (mem[lines[j]] !== golden[lines[j]])
            $display("FAIL rand_final_memory: line %h holds %h, required %h", lines[j], mem[lines[j]], golden[lines[j]]);
         else n_pass++;
      end
      n_checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0)
         $display("FAIL rand_quiescent: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
      else n_pass++;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin : main
      reset      = 1'b1;
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_address = '0;
      l2_wdata   = '0;
      for (int i = 0; i < 4096; i++) begin
         mem[i]    = rand128();
         golden[i] = mem[i];
      end
      test_reset();
      test_write_then_miss();
      test_hit_read();
      test_coalesce();
      test_write_miss();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
